// File: rtl/addr_seq_if.sv
// Handshake and control bundle between the address sequencer and the
// address-low unit / program-counter logic it steers.
interface addr_seq_if;
  logic       start;
  logic [2:0] mode;
  logic       RDY;
  logic       CO;
  logic [3:0] op;
  logic       CI;
  logic       ld_ahl;
  logic       ld_pc;
  logic       inc_pc;
  logic       ahi_inc;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, mode, RDY, CO,
    input  op, CI, ld_ahl, ld_pc, inc_pc, ahi_inc, busy, done, err
  );

  modport slave (
    input  start, mode, RDY, CO,
    output op, CI, ld_ahl, ld_pc, inc_pc, ahi_inc, busy, done, err
  );
endinterface

// File: rtl/addr_seq.sv
// Address sequencer: walks operand fetch, address formation, optional
// high-byte fix-up and completion for the ZP/ZPX/ABS/ABSX addressing modes.
module addr_seq (
  input  logic       clk,
  input  logic       rst_n,
  addr_seq_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, OPL, ADR, FIX, DONE} state_t;

  localparam logic [2:0] M_ABSX = 3'b011;

  state_t     state;
  logic [2:0] mode_q;
  logic       cy_q;
  logic       err_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mode_q <= 3'b000;
      cy_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (bus.RDY) begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              if (bus.mode[2]) begin
                err_q <= 1'b1;
              end else begin
                mode_q <= bus.mode;
                state  <= OPL;
              end
            end
          end
          OPL: state <= ADR;
          ADR: begin
            // Only the indexed-absolute form can cross a page; a ZPX carry
            // is dropped so the zero-page address wraps.
            if (mode_q == M_ABSX) cy_q <= bus.CO;
            state <= (mode_q == M_ABSX && bus.CO) ? FIX : DONE;
          end
          FIX:     state <= DONE;
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // NOTE: every output gets a default before the case so no path through
  // it can infer a latch.
  always_comb begin
    bus.op      = 4'b1100;
    bus.CI      = 1'b0;
    bus.ld_ahl  = 1'b0;
    bus.ld_pc   = 1'b0;
    bus.inc_pc  = 1'b0;
    bus.ahi_inc = 1'b0;
    bus.done    = 1'b0;
    bus.err     = 1'b0;
    bus.busy    = (state != IDLE);
    case (state)
      IDLE: bus.err = err_q && bus.RDY;
      OPL: begin
        bus.CI     = 1'b1;
        bus.ld_ahl = bus.RDY;
        bus.ld_pc  = bus.RDY;
        bus.inc_pc = bus.RDY;
      end
      ADR: begin
        case (mode_q[1:0])
          2'b00:   bus.op = 4'b0100;
          2'b01:   bus.op = 4'b0111;
          2'b10:   bus.op = 4'b1000;
          default: bus.op = 4'b1011;
        endcase
      end
      FIX: begin
        bus.op      = 4'b0010;
        bus.ahi_inc = bus.RDY && cy_q;
      end
      DONE: begin
        bus.op   = 4'b0010;
        bus.done = bus.RDY;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_addr_seq.sv
// Self-checking bench for addr_seq: directed mode/stall/reset cases followed
// by randomized sequences compared against a per-phase transaction model.
module tb_addr_seq;

  typedef enum int {PH_FETCH, PH_ADDR, PH_FIX, PH_FINISH} phase_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  addr_seq_if bus ();

  addr_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector: {op[3:0], CI, ld_ahl, ld_pc, inc_pc, ahi_inc, busy, done, err}
  function automatic logic [11:0] idle_rec(input logic e);
    return {4'b1100, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, e};
  endfunction

  // Address-low operation from the addressing mode's meaning: zero-page forms
  // take the low byte from DB, absolute forms from AHL; indexed forms add REG.
  function automatic logic [3:0] addr_op(input logic [1:0] m);
    logic [1:0] base;
    logic [1:0] addend;
    base   = m[1] ? 2'b10 : 2'b01;
    addend = m[0] ? 2'b11 : 2'b00;
    return {base, addend};
  endfunction

  function automatic logic [11:0] phase_rec(input phase_t ph, input logic [1:0] m,
                                            input logic rdy);
    case (ph)
      PH_FETCH:  return {4'b1100, 1'b1, rdy, rdy, rdy, 1'b0, 1'b1, 1'b0, 1'b0};
      PH_ADDR:   return {addr_op(m), 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
      PH_FIX:    return {4'b0010, 1'b0, 3'b000, rdy, 1'b1, 1'b0, 1'b0};
      default:   return {4'b0010, 1'b0, 3'b000, 1'b0, 1'b1, rdy, 1'b0};
    endcase
  endfunction

  task automatic check(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {bus.op, bus.CI, bus.ld_ahl, bus.ld_pc, bus.inc_pc,
           bus.ahi_inc, bus.busy, bus.done, bus.err};
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // start/mode are don't-cares outside IDLE, so drive them with noise.
  task automatic drive_noise();
    bus.start = 1'($urandom);
    bus.mode  = 3'($urandom);
    bus.CO    = 1'($urandom);
  endtask

  // One complete sequence. Stalls are either random or a single directed
  // stall before phase stall_phase; abort_phase asserts reset in that phase.
  task automatic run_seq(input logic [1:0] m, input logic co_adr,
                         input int stall_phase, input int stall_len,
                         input bit rnd, input int abort_phase);
    phase_t phases[$];
    int     stalls;
    phases.push_back(PH_FETCH);
    phases.push_back(PH_ADDR);
    if (m == 2'b11 && co_adr) phases.push_back(PH_FIX);
    phases.push_back(PH_FINISH);

    @(negedge clk);
    rst_n     = 1'b1;
    bus.start = 1'b1;
    bus.mode  = {1'b0, m};
    bus.RDY   = 1'b1;
    bus.CO    = 1'($urandom);
    #1 check("start_idle", idle_rec(1'b0));

    foreach (phases[i]) begin
      if (rnd) stalls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      else     stalls = (i == stall_phase) ? stall_len : 0;
      for (int s = 0; s < stalls; s++) begin
        @(negedge clk);
        drive_noise();
        bus.RDY = 1'b0;
        #1 check($sformatf("stall_%s", phases[i].name()), phase_rec(phases[i], m, 1'b0));
      end
      @(negedge clk);
      drive_noise();
      bus.RDY = 1'b1;
      if (phases[i] == PH_ADDR) bus.CO = co_adr;
      if (i == abort_phase) begin
        rst_n = 1'b0;
        #1 check($sformatf("abort_%s", phases[i].name()), idle_rec(1'b0));
        return;
      end
      #1 check(phases[i].name(), phase_rec(phases[i], m, 1'b1));
    end

    @(negedge clk);
    bus.start = 1'b0;
    bus.RDY   = 1'b1;
    #1 check("back_idle", idle_rec(1'b0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] rsv;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.mode  = 3'b000;
    bus.RDY   = 1'b0;
    bus.CO    = 1'b0;
    #1 check("reset", idle_rec(1'b0));

    // Start attempts while reset is held must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.RDY   = 1'b1;
    #1 check("reset_hold", idle_rec(1'b0));

    // Directed: first start right after reset release, then each mode.
    run_seq(2'b00, 1'b1, -1, 0, 1'b0, -1);  // ZP
    run_seq(2'b11, 1'b1, -1, 0, 1'b0, -1);  // ABSX page cross
    run_seq(2'b11, 1'b0, -1, 0, 1'b0, -1);  // ABSX no cross
    run_seq(2'b01, 1'b1, -1, 0, 1'b0, -1);  // ZPX wrap
    run_seq(2'b10, 1'b1, -1, 0, 1'b0, -1);  // ABS
    run_seq(2'b10, 1'b0,  0, 2, 1'b0, -1);  // two-cycle stall in OPL

    // Start with RDY low in IDLE is not taken.
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 3'b000;
    bus.RDY   = 1'b0;
    #1 check("idle_stall", idle_rec(1'b0));
    @(negedge clk);
    bus.start = 1'b0;
    bus.RDY   = 1'b1;
    #1 check("idle_stall_after", idle_rec(1'b0));

    // Reserved mode: err for exactly one cycle, never busy.
    @(negedge clk);
    rsv       = 3'b101;
    bus.start = 1'b1;
    bus.mode  = rsv;
    #1 check("rsv_start", idle_rec(1'b0));
    @(negedge clk);
    bus.start = 1'b0;
    #1 check("rsv_err", idle_rec(1'b1));
    @(negedge clk);
    #1 check("rsv_after", idle_rec(1'b0));

    // Reset asserted in FIX, then restart on the first edge after release.
    run_seq(2'b11, 1'b1, -1, 0, 1'b0, 2);
    @(negedge clk);
    #1 check("abort_hold", idle_rec(1'b0));
    run_seq(2'b00, 1'b0, -1, 0, 1'b0, -1);

    // Randomized sequences, including the odd reserved-mode start.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        rsv       = 3'($urandom_range(4, 7));
        bus.start = 1'b1;
        bus.mode  = rsv;
        bus.RDY   = 1'b1;
        #1 check("rnd_rsv_start", idle_rec(1'b0));
        @(negedge clk);
        bus.start = 1'b0;
        #1 check("rnd_rsv_err", idle_rec(1'b1));
      end
      run_seq(2'($urandom), 1'($urandom), -1, 0, 1'b1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
